// File: rtl/arv_pkg.sv
// arv_pkg: core-wide address/data widths and store buffer types.
// Shared by the store buffer, its FIFO and its interface.
package arv_pkg;

   localparam int PHY_ADDR_SIZE = 32;
   localparam int XLEN = 32;

   typedef struct packed {
      logic [PHY_ADDR_SIZE-1:0] addr;
      logic [XLEN-1:0]          data;
   } sb_entry_t;

   typedef enum logic {
      SB_IDLE,
      SB_WAIT_ACK
   } sb_state_e;

endpackage

// File: rtl/store_buffer_if.sv
// store_buffer_if: pipeline store port, memory write port,
// load forwarding lookup and status flags of the store buffer.
interface store_buffer_if;
   import arv_pkg::*;

   logic                     st_valid;
   logic                     st_ready;
   logic [PHY_ADDR_SIZE-1:0] st_addr;
   logic [XLEN-1:0]          st_data;
   logic                     wr_en;
   logic [PHY_ADDR_SIZE-1:0] wr_addr;
   logic [XLEN-1:0]          wr_data;
   logic                     wr_valid;
   logic [PHY_ADDR_SIZE-1:0] ld_addr;
   logic                     ld_hit;
   logic [XLEN-1:0]          ld_data;
   logic                     empty;
   logic                     err;

   modport master (
      output st_valid, st_addr, st_data, wr_valid, ld_addr,
      input  st_ready, wr_en, wr_addr, wr_data, ld_hit, ld_data,
      input  empty, err
   );

   modport slave (
      input  st_valid, st_addr, st_data, wr_valid, ld_addr,
      output st_ready, wr_en, wr_addr, wr_data, ld_hit, ld_data,
      output empty, err
   );

endinterface

// File: rtl/sb_fifo.sv
// sb_fifo: circular store FIFO with wrap-bit pointers.
// Exposes the raw entries when load forwarding is built in.
module sb_fifo
   import arv_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic      clk,
   input  logic      rst_n,
   input  logic      push,
   input  sb_entry_t push_entry,
   input  logic      pop,
   output sb_entry_t head,
   output logic      full,
   output logic      empty,
   output logic [AW:0] count
`ifdef STORE_BUFFER_FWD_EN
   ,
   output sb_entry_t entries [DEPTH],
   output logic [AW-1:0] head_idx
`endif
);

   sb_entry_t   mem [DEPTH];
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic        do_push;
   logic        do_pop;

   assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                  (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty = (wr_ptr == rd_ptr);
   assign count = wr_ptr - rd_ptr;
   assign head  = mem[rd_ptr[AW-1:0]];

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Payload storage needs no reset: only entries between the pointers are read.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= push_entry;
   end

`ifdef STORE_BUFFER_FWD_EN
   assign entries  = mem;
   assign head_idx = rd_ptr[AW-1:0];
`endif

endmodule

// File: rtl/store_buffer.sv
// store_buffer: in-order store drain with optional ack timeout.
// Define STORE_BUFFER_FWD_EN to build store-to-load forwarding.
module store_buffer
   import arv_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int ACK_TIMEOUT = 0
) (
   input logic           clk,
   input logic           rst_n,
   store_buffer_if.slave bus
);

   localparam int AW = $clog2(DEPTH);

   sb_state_e   state;
   sb_entry_t   st_entry;
   sb_entry_t   head;
   logic        full;
   logic        fifo_empty;
   logic [AW:0] count;
   logic        push;
   logic        pop;
   logic        last;
   logic        wr_en_q;

   assign st_entry = '{addr: bus.st_addr, data: bus.st_data};
   assign push     = bus.st_valid && !full;
   assign pop      = (state == SB_WAIT_ACK) && bus.wr_valid;
   assign last     = (count == (AW+1)'(1)) && !push;

`ifdef STORE_BUFFER_FWD_EN
   sb_entry_t   entries [DEPTH];
   logic [AW-1:0] head_idx;
`endif

   sb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (push),
      .push_entry (st_entry),
      .pop        (pop),
      .head       (head),
      .full       (full),
      .empty      (fifo_empty),
      .count      (count)
`ifdef STORE_BUFFER_FWD_EN
      ,
      .entries    (entries),
      .head_idx   (head_idx)
`endif
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= SB_IDLE;
         wr_en_q <= 1'b0;
      end else begin
         unique case (state)
            SB_IDLE: begin
               if (!fifo_empty) begin
                  state   <= SB_WAIT_ACK;
                  wr_en_q <= 1'b1;
               end
            end
            SB_WAIT_ACK: begin
               if (pop && last) begin
                  state   <= SB_IDLE;
                  wr_en_q <= 1'b0;
               end
            end
            default: begin
               state   <= SB_IDLE;
               wr_en_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.st_ready = !full;
   assign bus.wr_en    = wr_en_q;
   assign bus.wr_addr  = head.addr;
   assign bus.wr_data  = head.data;
   assign bus.empty    = fifo_empty && (state == SB_IDLE);

   generate
      if (ACK_TIMEOUT > 0) begin : g_tmo
         localparam int CW = $clog2(ACK_TIMEOUT + 1);
         logic [CW-1:0] cnt;
         logic          err_q;

         // Counter saturates at the limit; the write stays held after err.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               cnt   <= '0;
               err_q <= 1'b0;
            end else if (state != SB_WAIT_ACK || bus.wr_valid) begin
               cnt <= '0;
            end else if (cnt != CW'(ACK_TIMEOUT)) begin
               cnt <= cnt + 1'b1;
               if (cnt == CW'(ACK_TIMEOUT - 1)) err_q <= 1'b1;
            end
         end

         assign bus.err = err_q;
      end else begin : g_no_tmo
         assign bus.err = 1'b0;
      end
   endgenerate

`ifdef STORE_BUFFER_FWD_EN
   logic            fwd_hit;
   logic [XLEN-1:0] fwd_data;

   // Scan oldest to youngest so the youngest match overwrites earlier ones.
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (((AW+1)'(i) < count) &&
             (entries[head_idx + AW'(i)].addr == bus.ld_addr)) begin
            fwd_hit  = 1'b1;
            fwd_data = entries[head_idx + AW'(i)].data;
         end
      end
   end

   assign bus.ld_hit  = fwd_hit;
   assign bus.ld_data = fwd_data;
`else
   assign bus.ld_hit  = 1'b0;
   assign bus.ld_data = '0;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: random stores/acks against a queue model,
// then directed drain, full, forwarding, timeout and reset cases.
module tb_store_buffer;
   import arv_pkg::*;

   localparam int DEPTH = 4;
   localparam int TMO   = 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   store_buffer_if sbif ();

   store_buffer #(
      .DEPTH       (DEPTH),
      .ACK_TIMEOUT (TMO)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (sbif.slave)
   );

   always #5 clk = ~clk;

   int        checks = 0;
   int        errors = 0;
   sb_entry_t exp_q[$];
   bit        pushed_now = 0;
   bit        mon_on = 0;
   bit        stim_done = 0;
   int        prev_occ = 0;

`ifdef STORE_BUFFER_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] pick_addr();
      return 32'h200 + 32'($urandom_range(0, 3)) * 32'd4;
   endfunction

   // Model: a write is presented in any cycle where the buffer was
   // non-empty both in this cycle and in the one before.
   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (mon_on) begin
            int              occ;
            bit              exp_wr;
            bit              fh;
            logic [31:0]     fd;
            occ    = exp_q.size() - int'(pushed_now);
            exp_wr = (prev_occ != 0) && (occ != 0);
            chk("empty", sbif.empty, occ == 0);
            chk("wr_en", sbif.wr_en, exp_wr);
            chk("err", sbif.err, 0);
            fh = 0;
            fd = '0;
            if (FWD) begin
               for (int i = 0; i < occ; i++) begin
                  if (exp_q[i].addr == sbif.ld_addr) begin
                     fh = 1;
                     fd = exp_q[i].data;
                  end
               end
            end
            chk("ld_hit", sbif.ld_hit, fh);
            chk("ld_data", sbif.ld_data, fd);
            if (exp_wr) begin
               chk("wr_addr", sbif.wr_addr, exp_q[0].addr);
               chk("wr_data", sbif.wr_data, exp_q[0].data);
               if (sbif.wr_valid) void'(exp_q.pop_front());
            end
            prev_occ = occ;
         end
      end
   end

   task automatic stim(int n);
      for (int c = 0; c < n; c++) begin
         @(posedge clk);
         #1;
         pushed_now    = 0;
         sbif.st_valid = ($urandom_range(0, 9) < 6);
         sbif.st_addr  = pick_addr();
         sbif.st_data  = $urandom();
         sbif.ld_addr  = pick_addr();
         @(negedge clk);
         chk("st_ready", sbif.st_ready, exp_q.size() < DEPTH);
         if (sbif.st_valid && exp_q.size() < DEPTH) begin
            sb_entry_t e;
            e.addr = sbif.st_addr;
            e.data = sbif.st_data;
            exp_q.push_back(e);
            pushed_now = 1;
         end
      end
      @(posedge clk);
      #1;
      pushed_now    = 0;
      sbif.st_valid = 0;
      stim_done     = 1;
   endtask

   task automatic acker();
      int idle = 0;
      int cyc  = 0;
      while (!(stim_done && exp_q.size() == 0) && cyc < 20000) begin
         @(posedge clk);
         #1;
         cyc++;
         if (idle >= 4) begin
            sbif.wr_valid = 1;
            idle = 0;
         end else begin
            sbif.wr_valid = ($urandom_range(0, 2) == 0);
            if (sbif.wr_valid) idle = 0;
            else idle++;
         end
      end
      sbif.wr_valid = 0;
      chk("drain_done", 64'(exp_q.size()), 0);
   endtask

   task automatic wait_wr_en(string name);
      int n = 0;
      @(negedge clk);
      while (!sbif.wr_en && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk(name, sbif.wr_en, 1);
   endtask

   task automatic push1(logic [31:0] a, logic [31:0] d);
      @(posedge clk);
      #1;
      sbif.st_valid = 1;
      sbif.st_addr  = a;
      sbif.st_data  = d;
   endtask

   logic [31:0] t_addr [5];
   logic [31:0] t_data [5];

   initial begin
      sbif.st_valid = 0;
      sbif.st_addr  = '0;
      sbif.st_data  = '0;
      sbif.wr_valid = 0;
      sbif.ld_addr  = '0;
      #1 rst_n = 0;
      #1;
      chk("rst_st_ready", sbif.st_ready, 1);
      chk("rst_empty", sbif.empty, 1);
      chk("rst_wr_en", sbif.wr_en, 0);
      chk("rst_ld_hit", sbif.ld_hit, 0);
      chk("rst_ld_data", sbif.ld_data, 0);
      chk("rst_err", sbif.err, 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n  = 1;
      mon_on = 1;

      fork
         stim(400);
         acker();
      join
      @(posedge clk);
      #1;
      mon_on = 0;

      // Single store, ack on the third write cycle.
      sbif.ld_addr = '0;
      push1(32'h100, 32'hA5A5_0001);
      @(posedge clk);
      #1;
      sbif.st_valid = 0;
      wait_wr_en("d1_rise");
      for (int k = 0; k < 3; k++) begin
         if (k > 0) begin
            @(posedge clk);
            #1;
            sbif.wr_valid = (k == 2);
            @(negedge clk);
         end
         chk("d1_wr_en", sbif.wr_en, 1);
         chk("d1_wr_addr", sbif.wr_addr, 32'h100);
         chk("d1_wr_data", sbif.wr_data, 32'hA5A5_0001);
      end
      @(posedge clk);
      #1;
      sbif.wr_valid = 0;
      @(negedge clk);
      chk("d1_empty", sbif.empty, 1);
      chk("d1_wr_en_off", sbif.wr_en, 0);

      // Fill past capacity, forward, then drain back-to-back.
      t_addr = '{32'h200, 32'h300, 32'h200, 32'h400, 32'h200};
      t_data = '{32'h11, 32'h33, 32'h22, 32'h44, 32'h55};
      for (int i = 0; i < 5; i++) begin
         push1(t_addr[i], t_data[i]);
         @(negedge clk);
         chk("d2_st_ready", sbif.st_ready, i < 4);
      end
      @(posedge clk);
      #1;
      sbif.st_valid = 0;
      sbif.ld_addr  = 32'h200;
      @(negedge clk);
      chk("d2_full", sbif.st_ready, 0);
      chk("d2_hit", sbif.ld_hit, FWD);
      chk("d2_data", sbif.ld_data, FWD ? 32'h22 : 32'h0);
      @(posedge clk);
      #1;
      sbif.ld_addr = 32'h204;
      @(negedge clk);
      chk("d2_miss_hit", sbif.ld_hit, 0);
      chk("d2_miss_data", sbif.ld_data, 0);
      chk("d2_err_lo", sbif.err, 0);
      @(posedge clk);
      #1;
      sbif.wr_valid = 1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("d2_wr_en", sbif.wr_en, 1);
         chk("d2_wr_addr", sbif.wr_addr, t_addr[i]);
         chk("d2_wr_data", sbif.wr_data, t_data[i]);
         @(posedge clk);
         #1;
      end
      sbif.wr_valid = 0;
      @(negedge clk);
      chk("d2_empty", sbif.empty, 1);
      chk("d2_wr_en_off", sbif.wr_en, 0);

      // Acknowledge never arrives: err after the timeout, write held.
      push1(32'h500, 32'h5);
      @(posedge clk);
      #1;
      sbif.st_valid = 0;
      wait_wr_en("d3_rise");
      for (int k = 1; k <= TMO; k++) begin
         if (k > 1) @(negedge clk);
         chk("d3_err_lo", sbif.err, 0);
      end
      @(negedge clk);
      chk("d3_err_hi", sbif.err, 1);
      chk("d3_wr_held", sbif.wr_en, 1);
      chk("d3_wr_addr", sbif.wr_addr, 32'h500);
      @(posedge clk);
      #1;
      sbif.wr_valid = 1;
      @(posedge clk);
      #1;
      sbif.wr_valid = 0;
      @(negedge clk);
      chk("d3_err_sticky", sbif.err, 1);
      chk("d3_empty", sbif.empty, 1);

      // Reset with stores pending mid-write.
      sbif.ld_addr = 32'h600;
      for (int i = 0; i < 3; i++) push1(32'h600 + 32'(i) * 4, 32'(i + 1));
      @(posedge clk);
      #1;
      sbif.st_valid = 0;
      wait_wr_en("d4_rise");
      #2 rst_n = 0;
      #1;
      chk("d4_wr_en", sbif.wr_en, 0);
      chk("d4_empty", sbif.empty, 1);
      chk("d4_st_ready", sbif.st_ready, 1);
      chk("d4_ld_hit", sbif.ld_hit, 0);
      chk("d4_ld_data", sbif.ld_data, 0);
      chk("d4_err", sbif.err, 0);
      @(posedge clk);
      #1;
      rst_n = 1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("d4_post_wr_en", sbif.wr_en, 0);
         chk("d4_post_empty", sbif.empty, 1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
